// File: rtl/rv32_fetch_unit_pkg.sv
// Shared constants and types for the RV32 instruction fetch stage.
package rv32_fetch_unit_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES      = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Shift-register sync FIFO: the head always sits in entry 0 so it leaves a register directly.
// Empty slots hold FILL, which makes the head read FILL whenever the FIFO is empty.
module rv32_fetch_fifo #(
   parameter int               DEPTH = 2,
   parameter int               WIDTH = 64,
   parameter logic [WIDTH-1:0] FILL  = {WIDTH{1'b0}}
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   input  logic                           flush,
   output logic [WIDTH-1:0]               head,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_r   [DEPTH];
   logic [WIDTH-1:0] mem_nxt_s [DEPTH];
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_nxt_s;
   logic [CW-1:0]    wr_idx_s;
   logic             pop_s;
   logic             push_s;

   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == {CW{1'b0}});
   assign count = count_r;
   assign head  = mem_r[0];

   // Next storage image: shift on pop, write behind the last live entry on push.
   always_comb begin
      mem_nxt_s   = mem_r;
      count_nxt_s = count_r;
      pop_s       = pop && !empty;
      push_s      = push && (!full || pop_s);
      wr_idx_s    = count_r - CW'(pop_s);
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) mem_nxt_s[i] = FILL;
         count_nxt_s = {CW{1'b0}};
      end else begin
         if (pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_nxt_s[i] = mem_r[i+1];
            mem_nxt_s[DEPTH-1] = FILL;
         end else begin
            mem_nxt_s = mem_r;
         end
         if (push_s) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (int'(wr_idx_s) == i) mem_nxt_s[i] = push_data;
            end
         end else begin
            count_nxt_s = count_r;
         end
         count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= FILL;
         count_r <= {CW{1'b0}};
      end else begin
         mem_r   <= mem_nxt_s;
         count_r <= count_nxt_s;
      end
   end

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32 fetch stage: PC, credit-limited imem requests, PC-tag queue, instruction buffer,
// and redirect handling that discards responses still in flight at the redirect.
module rv32_fetch_unit
   import rv32_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_ir
);
   localparam int            CW      = $clog2(FIFO_DEPTH+1);
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);

   logic [31:0]  pc_r, pc_nxt_s;
   logic [CW-1:0] inflight_r, inflight_nxt_s;
   logic [CW-1:0] drop_r, drop_nxt_s;
   logic          started_r;
   logic          req_fire_s, rsp_live_s, credit_s;
   logic          buf_push_s, buf_pop_s, tag_pop_s, flush_s;
   logic          buf_empty_s, buf_full_s, tag_empty_s, tag_full_s;
   logic [CW-1:0] buf_count_s, tag_count_s;
   logic [31:0]   tag_head_s;
   fetch_entry_t  buf_head_s;
   logic          unused_ok_s;

   // started_r keeps the request channel quiet during the reset cycle itself.
   assign credit_s       = ({1'b0, inflight_r} + {1'b0, buf_count_s}) < DEPTH_W;
   assign imem_req_valid = started_r && !redirect_valid && credit_s && !tag_full_s;
   assign imem_req_addr  = pc_r;
   assign req_fire_s     = imem_req_valid && imem_req_ready;
   assign rsp_live_s     = imem_rsp_valid && (inflight_r != {CW{1'b0}});
   assign buf_pop_s      = id_valid && id_ready && !redirect_valid;
   assign id_valid       = !buf_empty_s;
   assign id_pc          = buf_head_s.pc;
   assign id_ir          = buf_head_s.ir;
   assign unused_ok_s    = ^{redirect_pc[1:0], buf_full_s, tag_count_s, tag_empty_s};

   // Next PC and counter values; a redirect overrides every other event this cycle.
   always_comb begin
      pc_nxt_s       = pc_r;
      inflight_nxt_s = inflight_r;
      drop_nxt_s     = drop_r;
      buf_push_s     = 1'b0;
      tag_pop_s      = 1'b0;
      flush_s        = 1'b0;
      if (redirect_valid) begin
         pc_nxt_s       = {redirect_pc[31:2], 2'b00};
         inflight_nxt_s = inflight_r - CW'(rsp_live_s);
         drop_nxt_s     = inflight_r - CW'(rsp_live_s);
         flush_s        = 1'b1;
      end else begin
         if (req_fire_s) begin
            pc_nxt_s = pc_r + INSTR_BYTES;
         end else begin
            pc_nxt_s = pc_r;
         end
         inflight_nxt_s = inflight_r + CW'(req_fire_s) - CW'(rsp_live_s);
         if (rsp_live_s && (drop_r != {CW{1'b0}})) begin
            drop_nxt_s = drop_r - CW'(1'b1);
         end else if (rsp_live_s) begin
            buf_push_s = 1'b1;
            tag_pop_s  = 1'b1;
         end else begin
            drop_nxt_s = drop_r;
         end
      end
   end

   // PC, credit and drop state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r       <= RESET_PC;
         inflight_r <= {CW{1'b0}};
         drop_r     <= {CW{1'b0}};
         started_r  <= 1'b0;
      end else begin
         pc_r       <= pc_nxt_s;
         inflight_r <= inflight_nxt_s;
         drop_r     <= drop_nxt_s;
         started_r  <= 1'b1;
      end
   end

   // Tags only track live requests; requests that will be dropped were flushed out.
   rv32_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32),
      .FILL  (32'h0000_0000)
   ) u_tag_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (req_fire_s),
      .push_data (pc_r),
      .pop       (tag_pop_s),
      .flush     (flush_s),
      .head      (tag_head_s),
      .count     (tag_count_s),
      .full      (tag_full_s),
      .empty     (tag_empty_s)
   );

   rv32_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (64),
      .FILL  ({32'h0000_0000, NOP_INSTR})
   ) u_ibuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (buf_push_s),
      .push_data ({tag_head_s, imem_rsp_data}),
      .pop       (buf_pop_s),
      .flush     (flush_s),
      .head      (buf_head_s),
      .count     (buf_count_s),
      .full      (buf_full_s),
      .empty     (buf_empty_s)
   );

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Directed bench for rv32_fetch_unit: streaming, stall, redirects, mid-run reset and PC wrap.
module tb_rv32_fetch_unit;
   import rv32_fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, imem_req_ready, redirect_valid, id_ready, sel;
   logic [31:0] redirect_pc;
   logic        req_valid1, req_valid2, rsp_valid, rsp_valid1, rsp_valid2;
   logic [31:0] req_addr1, req_addr2, rsp_data;
   logic        idv1, idv2;
   logic [31:0] idpc1, idpc2, idir1, idir2;
   logic        mreq_valid, mon_valid, mon_req_valid;
   logic [31:0] mreq_addr, mon_pc, mon_ir;
   int          lat = 1;
   int          cyc = 0;
   int          inflight = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];

   always #5 clk = ~clk;

   assign rsp_valid1    = rsp_valid && !sel;
   assign rsp_valid2    = rsp_valid && sel;
   assign mreq_valid    = sel ? req_valid2 : req_valid1;
   assign mreq_addr     = sel ? req_addr2 : req_addr1;
   assign mon_valid     = sel ? idv2 : idv1;
   assign mon_pc        = sel ? idpc2 : idpc1;
   assign mon_ir        = sel ? idir2 : idir1;
   assign mon_req_valid = mreq_valid;

   rv32_fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(req_valid1), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr1),
      .imem_rsp_valid(rsp_valid1), .imem_rsp_data(rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(idv1), .id_ready(id_ready), .id_pc(idpc1), .id_ir(idir1)
   );

   rv32_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr2),
      .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(idv2), .id_ready(id_ready), .id_pc(idpc2), .id_ir(idir2)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // In-order memory with programmable latency; lat=1 answers the cycle after acceptance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_addr.delete();
         pend_due.delete();
         rsp_valid <= 1'b0;
         rsp_data  <= 32'h0;
         inflight  <= 0;
      end else begin
         inflight  <= inflight + ((mreq_valid && imem_req_ready) ? 1 : 0) - (rsp_valid ? 1 : 0);
         rsp_valid <= 1'b0;
         if (mreq_valid && imem_req_ready) begin
            pend_addr.push_back(mreq_addr);
            pend_due.push_back(cyc + lat - 1);
         end
         if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_word(input string tag, input logic [31:0] pc);
      int k;
      k = 0;
      @(negedge clk);
      while (!mon_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check({tag, " valid"}, {31'd0, mon_valid}, 32'd1);
      check({tag, " pc"}, mon_pc, pc);
      check({tag, " ir"}, mon_ir, mem_word(pc));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int k;
      rst_n = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      id_ready = 1'b1; sel = 1'b0;
      @(negedge clk);
      check("rst id_valid", {31'd0, idv1}, 32'd0);
      check("rst id_ir", idir1, NOP_INSTR);
      check("rst id_pc", idpc1, 32'h0);
      check("rst req_valid", {31'd0, req_valid1}, 32'd0);
      check("rst req_addr", req_addr1, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) expect_word("stream", 32'(i * 4));

      // Hold decode off while word 0x14 is at the head.
      id_ready = 1'b0;
      repeat (5) @(negedge clk);
      check("stall req_valid", {31'd0, req_valid1}, 32'd0);
      check("stall id_valid", {31'd0, idv1}, 32'd1);
      check("stall id_pc", idpc1, 32'h14);
      check("stall id_ir", idir1, mem_word(32'h14));
      id_ready = 1'b1;
      @(negedge clk);
      check("stall buffered pc", idpc1, 32'h18);
      check("stall buffered valid", {31'd0, idv1}, 32'd1);
      expect_word("after stall", 32'h1C);

      rst_n = 1'b0;
      #1;
      check("midrst id_valid", {31'd0, idv1}, 32'd0);
      check("midrst id_ir", idir1, NOP_INSTR);
      check("midrst id_pc", idpc1, 32'h0);
      check("midrst req_valid", {31'd0, req_valid1}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_word("post rst", 32'h0);
      expect_word("post rst", 32'h4);

      // Redirect while two requests are outstanding.
      lat = 4;
      do_reset();
      k = 0;
      while (inflight != 2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("two inflight", 32'(inflight), 32'd2);
      check("two inflight no output", {31'd0, idv1}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      check("redirect req_valid", {31'd0, req_valid1}, 32'd0);
      @(negedge clk);
      redirect_valid = 1'b0;
      expect_word("redir drop", 32'h100);
      expect_word("redir drop", 32'h104);

      // Redirect coinciding with a response and a decode accept.
      lat = 1;
      id_ready = 1'b0;
      do_reset();
      k = 0;
      while (!(idv1 && rsp_valid) && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("collide setup", {30'd0, idv1, rsp_valid}, 32'd3);
      id_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      @(negedge clk);
      redirect_valid = 1'b0;
      check("collide flush valid", {31'd0, idv1}, 32'd0);
      check("collide flush ir", idir1, NOP_INSTR);
      expect_word("collide", 32'h200);
      expect_word("collide", 32'h204);

      // PC wrap on the second instance.
      sel = 1'b1;
      do_reset();
      expect_word("wrap", 32'hFFFF_FFF8);
      expect_word("wrap", 32'hFFFF_FFFC);
      expect_word("wrap", 32'h0000_0000);
      expect_word("wrap", 32'h0000_0004);
      check("wrap req_addr aligned", {30'd0, mreq_addr[1:0]}, 32'd0);
      check("wrap req_valid seen", {31'd0, mon_req_valid | idv2}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
